shift_sequencer: RTL and testbench

Multi-cycle shift unit controller for the RV32I core. It executes SLL/SRL/SRA(I) by iterating a 1-bit shift step once per clock for shamt cycles, rather than using a full barrel shifter. The step is the same single-position shift as the branch-offset shifter (left) plus its right-shift counterparts. It sits beside the ALU in EX; the hazard unit uses busy to stall the front of the pipeline, and the writeback mux takes result on done.

---
 rtl/shift_sequencer.sv | 91 +++++++++
 tb/tb_shift_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Iterative shift unit for SLL/SRL/SRA: one bit position per clock, shamt clocks per operation.
// Busy stalls the front of the pipeline; result is valid while done pulses.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | stepping data one position per clock, count holds steps left
// DONE  | result valid, done high for this cycle; a new start may be taken
module shift_sequencer #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [XLEN-1:0]    operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    result
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  state_t             state;
  logic [SHAMT_W-1:0] count;
  logic [XLEN-1:0]    data;
  logic [1:0]         op_q;

  assign result = data;

  // busy and done are registered alongside the state so they track it exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      data  <= '0;
      op_q  <= OP_SLL;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= 1'b0;
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              data  <= operand;
              op_q  <= op;
              count <= shamt;
              if (shamt != '0 && op != OP_RSV) begin
                state <= SHIFT;
                busy  <= 1'b1;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end else begin
              state <= IDLE;
            end
          end
          SHIFT: begin
            case (op_q)
              OP_SLL:  data <= {data[XLEN-2:0], 1'b0};
              OP_SRL:  data <= {1'b0, data[XLEN-1:1]};
              OP_SRA:  data <= {data[XLEN-1], data[XLEN-1:1]};
              default: data <= data;
            endcase
            count <= count - SHAMT_W'(1);
            if (count == SHAMT_W'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              busy  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus randomized operations
// checked against an arithmetic shift model, including ignored starts, flush and reset aborts.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand;
  logic [4:0]  shamt;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  shift_sequencer #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .operand(operand),
    .shamt(shamt), .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_result(logic [1:0] o, logic [31:0] v, int s);
    case (o)
      2'b00:   return v << s;
      2'b01:   return v >> s;
      2'b10:   return 32'($signed(v) >>> s);
      default: return v;
    endcase
  endfunction

  function automatic int model_latency(logic [1:0] o, int s);
    return (s == 0 || o == 2'b11) ? 1 : s + 1;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [1:0] o, logic [31:0] v, logic [4:0] s);
    start   = 1'b1;
    op      = o;
    operand = v;
    shamt   = s;
    next_cycle();
    start   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; op = 2'b00; operand = '0; shamt = '0; flush = 1'b0;
    #3;
    tests++;
    if ({busy, done, result} !== 34'd0) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b result=%h expected 0/0/00000000", busy, done, result);
    end
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    tests++;
    if ({busy, done, result} !== 34'd0) begin
      fails++;
      $display("FAIL reset_release: busy=%b done=%b result=%h expected 0/0/00000000", busy, done, result);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  d_op  [5] = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b11};
    logic [31:0] d_val [5] = '{32'h1, 32'h80000000, 32'h80000000, 32'hDEADBEEF, 32'hDEADBEEF};
    logic [4:0]  d_sh  [5] = '{5'd31, 5'd4, 5'd4, 5'd0, 5'd7};
    logic [31:0] d_exp [5] = '{32'h80000000, 32'hF8000000, 32'h08000000, 32'hDEADBEEF, 32'hDEADBEEF};
    int lat;
    for (int i = 0; i < 5; i++) begin
      lat = model_latency(d_op[i], int'(d_sh[i]));
      issue(d_op[i], d_val[i], d_sh[i]);
      for (int c = 1; c <= lat + 1; c++) begin
        tests++;
        if (busy !== (c < lat) || done !== (c == lat)) begin
          fails++;
          $display("FAIL directed%0d cycle %0d: busy=%b done=%b expected busy=%b done=%b",
                   i, c, busy, done, (c < lat), (c == lat));
        end
        if (c >= lat) begin
          tests++;
          if (result !== d_exp[i]) begin
            fails++;
            $display("FAIL directed%0d result cycle %0d: got %h expected %h", i, c, result, d_exp[i]);
          end
        end
        next_cycle();
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  r_op;
    logic [31:0] r_val, exp;
    logic [4:0]  r_sh;
    int lat;
    for (int t = 0; t < 60; t++) begin
      r_op  = 2'($urandom_range(0, 3));
      r_val = $urandom;
      r_sh  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      exp   = model_result(r_op, r_val, int'(r_sh));
      lat   = model_latency(r_op, int'(r_sh));
      issue(r_op, r_val, r_sh);
      for (int c = 1; c <= lat + 1; c++) begin
        tests++;
        if (busy !== (c < lat) || done !== (c == lat)) begin
          fails++;
          $display("FAIL random%0d cycle %0d: busy=%b done=%b expected busy=%b done=%b",
                   t, c, busy, done, (c < lat), (c == lat));
        end
        if (c >= lat) begin
          tests++;
          if (result !== exp) begin
            fails++;
            $display("FAIL random%0d result op=%0d sh=%0d: got %h expected %h", t, r_op, r_sh, result, exp);
          end
        end
        // while shifting, a held or noisy start must not disturb the operation
        if (c < lat) begin
          start   = 1'($urandom_range(0, 1));
          op      = 2'($urandom_range(0, 3));
          operand = $urandom;
          shamt   = 5'($urandom_range(0, 31));
        end else begin
          start = 1'b0;
        end
        next_cycle();
      end
    end
  endtask

  task automatic test_start_ignored();
    issue(2'b01, 32'hFFFF0000, 5'd8);
    for (int c = 1; c <= 10; c++) begin
      tests++;
      if (busy !== (c < 9) || done !== (c == 9)) begin
        fails++;
        $display("FAIL start_ignored cycle %0d: busy=%b done=%b expected busy=%b done=%b",
                 c, busy, done, (c < 9), (c == 9));
      end
      if (c == 9) begin
        tests++;
        if (result !== 32'h00FFFF00) begin
          fails++;
          $display("FAIL start_ignored result: got %h expected 00ffff00", result);
        end
      end
      if (c == 3) begin
        start = 1'b1; op = 2'b01; operand = 32'h1; shamt = 5'd8;
      end else begin
        start = 1'b0;
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    issue(2'b00, 32'h3, 5'd2);
    next_cycle();
    next_cycle();
    tests++;
    if (done !== 1'b1 || result !== 32'h0000000C) begin
      fails++;
      $display("FAIL b2b_first: done=%b result=%h expected 1/0000000c", done, result);
    end
    issue(2'b10, 32'hF0000000, 5'd1);
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_cycle4: busy=%b done=%b expected 1/0", busy, done);
    end
    next_cycle();
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== 32'hF8000000) begin
      fails++;
      $display("FAIL b2b_second: busy=%b done=%b result=%h expected 0/1/f8000000", busy, done, result);
    end
    next_cycle();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_done_pulse: done=%b expected 0", done);
    end
  endtask

  task automatic test_flush();
    logic [31:0] held;
    issue(2'b00, 32'h1, 5'd10);
    next_cycle();
    next_cycle();
    next_cycle();
    held  = 32'h1 << 3;
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    for (int c = 5; c <= 15; c++) begin
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL flush cycle %0d: busy=%b done=%b expected 0/0", c, busy, done);
      end
      next_cycle();
    end
    tests++;
    if (result !== held) begin
      fails++;
      $display("FAIL flush_result: got %h expected %h", result, held);
    end
  endtask

  task automatic test_reset_mid();
    issue(2'b00, 32'h1, 5'd10);
    for (int c = 1; c < 6; c++) next_cycle();
    rst = 1'b0;
    #1;
    tests++;
    if ({busy, done, result} !== 34'd0) begin
      fails++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h expected 0/0/00000000", busy, done, result);
    end
    next_cycle();
    rst = 1'b1;
    for (int c = 0; c < 14; c++) begin
      next_cycle();
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid_after %0d: busy=%b done=%b expected 0/0", c, busy, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
